// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: key codes, frame-result payload,
// FSM state encoding and the (row, col) -> key code map.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } frame_res_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_e;

    // Result of one full scan frame; code is KEY_NONE unless res is RES_SINGLE
    typedef struct packed {
        frame_res_e res;
        logic [3:0] code;
    } frame_t;

    // Layout: r0: 1 2 3  r1: 4 5 6  r2: 7 8 9  r3: * 0 #
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column scanner: synchronizes the rows, drives one column low at a time for
// DWELL clocks, and summarizes each 3-column frame as NONE/SINGLE/MULTI.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   key_row     raw active-low rows (asynchronous)
//   key_col     active-low column drive, exactly one bit low
//   frame_done  one-cycle strobe when frame holds a new result
//   frame       frame result and single-key code
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic       frame_done,
    output frame_t     frame
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    logic [3:0]      row_meta_q, row_meta_d;
    logic [3:0]      row_sync_q, row_sync_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [2:0]      col_q, col_d;
    logic [1:0]      hits_q, hits_d;
    logic [3:0]      acc_code_q, acc_code_d;
    logic            frame_done_q, frame_done_d;
    frame_t          frame_q, frame_d;

    logic [3:0] low;
    logic [2:0] n_low;
    logic [2:0] hit_sum;
    logic [1:0] col_idx;
    logic [1:0] row_idx;
    logic [3:0] code_now;

    // Next-state: sync chain, dwell/column rotation, per-frame low-bit tally
    always_comb begin
        row_meta_d   = key_row;
        row_sync_d   = row_meta_q;
        dwell_d      = dwell_q;
        col_d        = col_q;
        hits_d       = hits_q;
        acc_code_d   = acc_code_q;
        frame_done_d = 1'b0;
        frame_d      = frame_q;

        low     = ~row_sync_q;
        n_low   = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
        hit_sum = 3'({1'b0, hits_q}) + n_low;

        case (col_q)
            3'b101:  col_idx = 2'd1;
            3'b011:  col_idx = 2'd2;
            default: col_idx = 2'd0;
        endcase

        row_idx = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (low[r]) row_idx = 2'(r);
        end

        // Only the first low bit of the frame can be the single key's code
        code_now = (n_low == 3'd1 && hits_q == 2'd0) ? key_map(row_idx, col_idx) : acc_code_q;

        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            col_d   = {col_q[1:0], col_q[2]};
            if (col_idx == 2'd2) begin
                frame_done_d = 1'b1;
                case (hit_sum)
                    3'd0:    frame_d.res = RES_NONE;
                    3'd1:    frame_d.res = RES_SINGLE;
                    default: frame_d.res = RES_MULTI;
                endcase
                frame_d.code = (hit_sum == 3'd1) ? code_now : KEY_NONE;
                hits_d       = '0;
                acc_code_d   = KEY_NONE;
            end else begin
                hits_d     = (hit_sum >= 3'd2) ? 2'd2 : 2'(hit_sum);
                acc_code_d = code_now;
            end
        end else begin
            dwell_d = dwell_q + DW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q   <= 4'hF;
            row_sync_q   <= 4'hF;
            dwell_q      <= '0;
            col_q        <= 3'b110;
            hits_q       <= '0;
            acc_code_q   <= KEY_NONE;
            frame_done_q <= 1'b0;
            frame_q      <= '{res: RES_NONE, code: KEY_NONE};
        end else begin
            row_meta_q   <= row_meta_d;
            row_sync_q   <= row_sync_d;
            dwell_q      <= dwell_d;
            col_q        <= col_d;
            hits_q       <= hits_d;
            acc_code_q   <= acc_code_d;
            frame_done_q <= frame_done_d;
            frame_q      <= frame_d;
        end
    end

    assign key_col    = col_q;
    assign frame_done = frame_done_q;
    assign frame      = frame_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner with frame-level debounce; drives level-style key lines
// for the watch plus a one-cycle key_valid/key_code strobe.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   key_row     keypad rows, active-low, asynchronous
//   key_col     keypad columns, active-low, one low at a time
//   num_input   bit d high while digit d is held
//   set_time    high while '#' is held
//   star        high while '*' is held
//   key_valid   one-cycle strobe on a newly accepted press
//   key_code    accepted key code, KEY_NONE when nothing held
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned DWELL      = 4,
    parameter int unsigned DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [9:0] num_input,
    output logic       set_time,
    output logic       star,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int unsigned CW = $clog2(DEB_FRAMES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_FRAMES - 1);

    logic   frame_done;
    frame_t frame;

    keypad_col_scan #(.DWELL(DWELL)) u_col_scan (
        .clk        (clk),
        .rst        (rst),
        .key_row    (key_row),
        .key_col    (key_col),
        .frame_done (frame_done),
        .frame      (frame)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [9:0]    num_input_q, num_input_d;
    logic          set_time_q, set_time_d;
    logic          star_q, star_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          accept;
    logic          release_keys;

    // Debounce FSM, stepped once per frame, plus registered key outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rcnt_d       = rcnt_q;
        cand_d       = cand_q;
        num_input_d  = num_input_q;
        set_time_d   = set_time_q;
        star_d       = star_q;
        key_valid_d  = 1'b0;
        key_code_d   = key_code_q;
        accept       = 1'b0;
        release_keys = 1'b0;

        if (frame_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame.res == RES_SINGLE) begin
                        cand_d = frame.code;
                        cnt_d  = CW'(1);
                        if (DEB_FRAMES == 1) accept = 1'b1;
                        else                 state_d = ST_DEBOUNCE;
                    end else if (frame.res == RES_MULTI) begin
                        state_d = ST_LOCKOUT;
                        rcnt_d  = '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame.res == RES_SINGLE) begin
                        if (frame.code == cand_q) begin
                            if (cnt_q == DEB_LAST) accept = 1'b1;
                            else                   cnt_d = cnt_q + CW'(1);
                        end else begin
                            cand_d = frame.code;
                            cnt_d  = CW'(1);
                        end
                    end else if (frame.res == RES_MULTI) begin
                        state_d = ST_LOCKOUT;
                        cnt_d   = '0;
                        rcnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED, ST_LOCKOUT: begin
                    if (frame.res == RES_NONE) begin
                        if (rcnt_q == DEB_LAST) begin
                            state_d      = ST_IDLE;
                            rcnt_d       = '0;
                            release_keys = (state_q == ST_PRESSED);
                        end else begin
                            rcnt_d = rcnt_q + CW'(1);
                        end
                    end else begin
                        rcnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (accept) begin
            state_d     = ST_PRESSED;
            cnt_d       = '0;
            rcnt_d      = '0;
            key_valid_d = 1'b1;
            key_code_d  = cand_d;
            for (int d = 0; d < 10; d++) begin
                num_input_d[d] = (cand_d == 4'(d));
            end
            star_d     = (cand_d == KEY_STAR);
            set_time_d = (cand_d == KEY_HASH);
        end

        if (release_keys) begin
            num_input_d = '0;
            set_time_d  = 1'b0;
            star_d      = 1'b0;
            key_code_d  = KEY_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            cand_q      <= KEY_NONE;
            num_input_q <= '0;
            set_time_q  <= 1'b0;
            star_q      <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= KEY_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            cand_q      <= cand_d;
            num_input_q <= num_input_d;
            set_time_q  <= set_time_d;
            star_q      <= star_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign num_input = num_input_q;
    assign set_time  = set_time_q;
    assign star      = star_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner. The keypad is a wired-AND of the
// held-key mask against the driven column; key changes are applied at frame
// starts so the reference model works purely at frame level.
module tb_keypad_scanner;

    localparam int DWELL = 4;
    localparam int DEB   = 4;
    localparam int FRAME = 3 * DWELL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [9:0] num_input;
    logic       set_time;
    logic       star;
    logic       key_valid;
    logic [3:0] key_code;

    logic [11:0] mask = '0;       // bit r*3+c = key at row r, column c held
    logic [11:0] prev_mask = '0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;

    // Reference model state (frame granularity)
    int m_cand, m_stable, m_quiet;
    bit m_held, m_locked, m_valid;

    keypad_scanner #(.DWELL(DWELL), .DEB_FRAMES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .num_input (num_input),
        .set_time  (set_time),
        .star      (star),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            key_row[r] = ~|(mask[r*3 +: 3] & ~key_col);
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) pulses++;
    end

    function automatic int code_of(input int k);
        int tbl [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
        return tbl[k];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cand = -1; m_stable = 0; m_quiet = 0;
        m_held = 0; m_locked = 0; m_valid = 0;
    endtask

    // One completed frame with held mask m
    task automatic model_step(input logic [11:0] m);
        int n;
        int code;
        n = $countones(m);
        code = -1;
        for (int k = 0; k < 12; k++) if (m[k]) code = code_of(k);
        m_valid = 0;
        if (m_held || m_locked) begin
            m_quiet = (n == 0) ? m_quiet + 1 : 0;
            if (m_quiet == DEB) begin
                m_held = 0; m_locked = 0; m_quiet = 0; m_cand = -1;
            end
        end else if (n == 0) begin
            m_cand = -1; m_stable = 0;
        end else if (n >= 2) begin
            m_locked = 1; m_quiet = 0; m_cand = -1; m_stable = 0;
        end else begin
            if (code == m_cand) m_stable++;
            else begin
                m_cand = code; m_stable = 1;
            end
            if (m_stable == DEB) begin
                m_held = 1; m_quiet = 0; m_stable = 0; m_valid = 1;
                exp_pulses++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [9:0] one;
        logic [9:0] exp_num;
        one = 10'd1;
        exp_num = (m_held && m_cand < 10) ? (one << m_cand) : 10'd0;
        check({tag, ".key_valid"}, 16'(key_valid), 16'(m_valid));
        check({tag, ".key_code"},  16'(key_code),  m_held ? 16'(m_cand) : 16'hF);
        check({tag, ".num_input"}, 16'(num_input), 16'(exp_num));
        check({tag, ".star"},      16'(star),      16'(m_held && m_cand == 10));
        check({tag, ".set_time"},  16'(set_time),  16'(m_held && m_cand == 11));
    endtask

    // Entered and left at the negedge just after a frame-start edge
    task automatic run_frame(input string tag, input logic [11:0] m);
        logic [2:0] exp_col;
        model_step(prev_mask);
        mask = m;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) check_outputs(tag);
            case (i / DWELL)
                0:       exp_col = 3'b110;
                1:       exp_col = 3'b101;
                default: exp_col = 3'b011;
            endcase
            check({tag, ".key_col"}, 16'(key_col), 16'(exp_col));
        end
        prev_mask = m;
        @(negedge clk);
    endtask

    task automatic hold_key(input string tag, input int k, input int frames);
        logic [11:0] m;
        m = 12'd1 << k;
        repeat (frames) run_frame(tag, m);
    endtask

    task automatic idle(input string tag, input int frames);
        repeat (frames) run_frame(tag, 12'd0);
    endtask

    initial begin
        logic [11:0] m;
        int a, b, sel;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.key_col",   16'(key_col),   16'h6);
        check("rst.num_input", 16'(num_input), 16'h0);
        check("rst.set_time",  16'(set_time),  16'h0);
        check("rst.star",      16'(star),      16'h0);
        check("rst.key_valid", 16'(key_valid), 16'h0);
        check("rst.key_code",  16'(key_code),  16'hF);
        rst = 1'b0;
        idle("idle", 2);

        // Clean '5' press and release
        hold_key("key5", 4, 10);
        idle("rel5", 6);

        // '7' bouncing at frame level, then held
        hold_key("b7", 6, 1);
        idle("b7", 1);
        hold_key("b7", 6, 2);
        idle("b7", 1);
        hold_key("key7", 6, 8);
        idle("rel7", 6);

        // '1'+'2' together -> lockout, then clean '2'
        run_frame("multi", 12'b0000_0000_0011);
        repeat (7) run_frame("multi", 12'b0000_0000_0011);
        idle("relm", 5);
        hold_key("key2", 1, 6);
        idle("rel2", 6);

        // '#' and '*'
        hold_key("hash", 11, 6);
        idle("relh", 5);
        hold_key("star", 9, 6);
        idle("rels", 5);

        // Reset while '9' held, then re-debounce with no extra strobe
        hold_key("key9", 8, 6);
        rst = 1'b1;
        @(negedge clk);
        check("midrst.num_input", 16'(num_input), 16'h0);
        check("midrst.key_code",  16'(key_code),  16'hF);
        check("midrst.key_valid", 16'(key_valid), 16'h0);
        rst = 1'b0;
        model_reset();
        prev_mask = '0;
        hold_key("key9r", 8, 10);
        idle("rel9", 6);

        // Randomized keypad activity
        repeat (40) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                m = '0;
            end else if (sel < 9) begin
                m = 12'd1 << $urandom_range(0, 11);
            end else begin
                a = $urandom_range(0, 11);
                b = (a + 1 + $urandom_range(0, 10)) % 12;
                m = (12'd1 << a) | (12'd1 << b);
            end
            repeat ($urandom_range(1, 6)) run_frame("rand", m);
        end
        idle("final", 6);

        check("pulse_count", 16'(pulses), 16'(exp_pulses));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
